// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential multiplier.
//   - state_t      : FSM state encoding (IDLE / RUN / DONE)
//   - DATA_WIDTH_DEFAULT : default operand width
//   - cnt_width()  : width of the per-run bit counter
package mul_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// adder: plain unsigned combinational adder.
//   DATA_WIDTH : operand and result width
//   a, b       : addends
//   sum        : a + b, truncated to DATA_WIDTH
module adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle unsigned shift-and-add multiplier.
// One conditional add and one right shift per cycle for DATA_WIDTH cycles.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   start   : request a multiply (accepted in IDLE or DONE)
//   a, b    : multiplicand / multiplier, sampled on the accepting edge
//   busy    : high while the multiply is running
//   done    : one-cycle pulse when product is valid
//   product : registered 2*DATA_WIDTH result, held until the next completion
module mul_seq
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH:0]   add_a;
  logic [DATA_WIDTH:0]   add_b;
  logic [DATA_WIDTH:0]   sum;

  // Carry is kept in sum[DATA_WIDTH]; it becomes the top bit of acc_hi
  // after the shift, so nothing is lost.
  assign add_a = {1'b0, acc_hi};
  assign add_b = acc_lo[0] ? {1'b0, mcand} : '0;

  adder #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_add (
    .a  (add_a),
    .b  (add_b),
    .sum(sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // {acc_hi, acc_lo} <= {sum, acc_lo} >> 1; start is ignored here.
          acc_hi <= sum[DATA_WIDTH:1];
          acc_lo <= {sum[0], acc_lo[DATA_WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            product <= {sum, acc_lo[DATA_WIDTH-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed bench for mul_seq with a product scoreboard.
module tb_mul_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int tests = 0;
  int fails = 0;
  int done_count = 0;
  logic [2*W-1:0] exp_q[$];

  mul_seq #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // Monitor: pops an expected product on every done pulse.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b1)
        check("busy_done_overlap", 1, 0);
      if (done === 1'b1) begin
        done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", product, '1);
        end else begin
          e = exp_q.pop_front();
          check("product", product, e);
        end
      end
    end
  end

  // Issue start for one cycle; returns after the accepting edge (+1).
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = '1; b = '1;  // operands change after accept
  endtask

  // Wait for done (sampled #1 after edges); returns edges waited.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0; busy_cycles = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic mul_case(input string name, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [2*W-1:0] ev);
    int edges, bc;
    $display("[TB] case %s", name);
    exp_q.push_back(ev);
    issue(av, bv);
    wait_done(edges, bc);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
    check({name, "_latency"}, 64'(edges), 64'd32);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int edges, bc, d0;
    start = 1'b0; a = '0; b = '0;
    reset = 1'b1;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    mul_case("basic_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    mul_case("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    mul_case("zero_b", 32'h1234_5678, 32'd0, 64'd0);

    // Start during run is ignored.
    $display("[TB] case start_during_run");
    d0 = done_count;
    exp_q.push_back(64'd42);
    issue(32'd7, 32'd6);
    repeat (8) @(posedge clk);
    #1 start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    wait_done(edges, bc);
    repeat (40) @(posedge clk);
    #1 check("single_done", 64'(done_count - d0), 64'd1);

    // Reset mid-run: outputs clear immediately, no result emitted.
    $display("[TB] case reset_mid_run");
    issue(32'd5, 32'd5);
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_product", product, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Back-to-back: start held in the DONE cycle with new operands.
    $display("[TB] case back_to_back");
    exp_q.push_back(64'd6);
    issue(32'd2, 32'd3);
    wait_done(edges, bc);
    start = 1'b1; a = 32'd4; b = 32'd4;
    exp_q.push_back(64'd16);
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    check("b2b_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(edges, bc);
    check("b2b_spacing", 64'(edges + 1), 64'd33);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
